// File: rtl/rr_mux_stage_if.sv
// rr_mux_stage_if: producer and consumer handshake
// bundle for the arbitrating output stage.
interface rr_mux_stage_if #(
  parameter int N  = 8,
  parameter int W  = 64,
  parameter int CW = $clog2(N)
);
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [CW-1:0]  out_chan;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_chan
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_chan
  );
endinterface

// File: rtl/rr_mux_stage.sv
// rr_mux_stage: N-way arbitrating mux with one
// registered output slot (round-robin or fixed).
module rr_mux_stage #(
  parameter int N  = 8,
  parameter int W  = 64,
  parameter int RR = 1,
  parameter int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  rr_mux_stage_if.slave bus
);

  logic [W-1:0]  chan_data [N];
  logic [CW-1:0] ptr;
  logic [CW-1:0] base;
  logic [CW-1:0] gidx;
  logic [N-1:0]  gnt;
  logic [N-1:0]  rdy;
  logic          hit;
  logic          can_load;
  logic          take;
  logic          ov_q;
  logic [W-1:0]  od_q;
  logic [CW-1:0] oc_q;

  for (genvar g = 0; g < N; g++) begin : g_slice
    assign chan_data[g] = bus.in_data[g*W +: W];
  end

  // Channel index k steps after base, wrapping at N.
  function automatic logic [CW-1:0] slot(
    logic [CW-1:0] b,
    int            k
  );
    int s;
    s = int'(b) + k;
    if (s >= N) s = s - N;
    return CW'(s);
  endfunction

  assign base     = (RR != 0) ? ptr : '0;
  assign can_load = !ov_q || bus.out_ready;

  // Grant: first requester found scanning up from base.
  always_comb begin
    gnt  = '0;
    gidx = '0;
    hit  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!hit && bus.in_valid[slot(base, k)]) begin
        hit            = 1'b1;
        gidx           = slot(base, k);
        gnt[slot(base, k)] = 1'b1;
      end
    end
  end

  assign rdy  = (!reset && can_load) ? gnt : '0;
  assign take = |rdy;

  // Output slot and pointer; a load wins over a drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      ov_q <= 1'b0;
      od_q <= '0;
      oc_q <= '0;
      ptr  <= '0;
    end else if (take) begin
      ov_q <= 1'b1;
      od_q <= chan_data[gidx];
      oc_q <= gidx;
      if (RR != 0) begin
        ptr <= (gidx == CW'(N - 1)) ? '0 : gidx + CW'(1);
      end
    end else if (ov_q && bus.out_ready) begin
      ov_q <= 1'b0;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
  assign bus.out_chan  = oc_q;

endmodule

// File: tb/tb_rr_mux_stage.sv
// tb_rr_mux_stage: directed vectors plus a random
// phase with mid-run reset, checked via scoreboards.
module tb_rr_mux_stage;
  localparam int N  = 8;
  localparam int W  = 64;
  localparam int CW = 3;

  typedef struct packed {
    logic [CW-1:0] chan;
    logic [W-1:0]  data;
  } word_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rr_mux_stage_if #(.N(N), .W(W)) a ();
  rr_mux_stage_if #(.N(N), .W(W)) b ();

  rr_mux_stage #(.N(N), .W(W), .RR(1)) u_rr (
    .clk   (clk),
    .reset (reset),
    .bus   (a.slave)
  );

  rr_mux_stage #(.N(N), .W(W), .RR(0)) u_fp (
    .clk   (clk),
    .reset (reset),
    .bus   (b.slave)
  );

  word_t qa[$];
  word_t qb[$];
  int total = 0;
  int bad = 0;
  bit model_on = 1'b0;
  bit prev_rst = 1'b0;
  int m_ptr = 0;
  bit m_ov = 1'b0;
  logic [N-1:0] m_acc = '0;
  logic [N-1:0] pend = '0;
  logic [W-1:0] pdata [N];
  int seq = 0;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic word_t mk(int ch, logic [W-1:0] d);
    word_t w;
    w.chan = CW'(ch);
    w.data = d;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arbiter for the random phase.
  task automatic model_step();
    bit found;
    bit cl;
    int jj;
    int j;
    logic [N-1:0] er;
    found = 1'b0;
    jj = 0;
    er = '0;
    if (prev_rst) chk("rst_clear_ov", a.out_valid, 0);
    prev_rst = reset;
    if (reset) begin
      chk("rst_ready", a.in_ready, 0);
      qa.delete();
      m_ov = 1'b0;
      m_ptr = 0;
      m_acc = '0;
      return;
    end
    cl = !m_ov || a.out_ready;
    for (int k = 0; k < N; k++) begin
      j = (m_ptr + k) % N;
      if (!found && a.in_valid[j]) begin
        found = 1'b1;
        jj = j;
      end
    end
    if (cl && found) er[jj] = 1'b1;
    chk("rand_ready", a.in_ready, er);
    if (cl && found) begin
      qa.push_back(mk(jj, pdata[jj]));
      m_acc[jj] = 1'b1;
      m_ptr = (jj == N - 1) ? 0 : jj + 1;
      m_ov = 1'b1;
    end else if (m_ov && a.out_ready) begin
      m_ov = 1'b0;
    end
  endtask

  // Monitor: pop and compare on every output drain.
  always @(negedge clk) begin
    if (!reset && a.out_valid && a.out_ready) begin
      if (qa.size() == 0) begin
        total++;
        bad++;
        $display("FAIL a_extra: chan %0d data %h, none expected",
                 a.out_chan, a.out_data);
      end else begin : pa
        word_t e;
        e = qa.pop_front();
        chk("a_chan", a.out_chan, e.chan);
        chk("a_data", a.out_data, e.data);
      end
    end
    if (!reset && b.out_valid && b.out_ready) begin
      if (qb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL b_extra: chan %0d data %h, none expected",
                 b.out_chan, b.out_data);
      end else begin : pb
        word_t e;
        e = qb.pop_front();
        chk("b_chan", b.out_chan, e.chan);
        chk("b_data", b.out_data, e.data);
      end
    end
    if (model_on) model_step();
  end

  typedef struct {
    logic [N-1:0] v;
    int g;
  } fp_t;

  fp_t fp_vec [7] = '{
    '{8'h92, 1}, '{8'h92, 1}, '{8'h92, 1},
    '{8'h90, 4}, '{8'h90, 4},
    '{8'h80, 7}, '{8'h80, 7}
  };

  initial begin
    reset = 1'b1;
    a.in_valid = '1;
    a.out_ready = 1'b1;
    b.in_valid = '1;
    b.out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      a.in_data[i*W +: W] = 64'hA0 + 64'(i);
      b.in_data[i*W +: W] = 64'hB0 + 64'(i);
      pdata[i] = '0;
    end
    tick();
    @(negedge clk);
    chk("rst_in_ready", a.in_ready, 0);
    chk("rst_out_valid", a.out_valid, 0);
    chk("rst_out_data", a.out_data, 0);
    chk("rst_out_chan", a.out_chan, 0);
    chk("rst_fp_ready", b.in_ready, 0);
    tick();
    @(negedge clk);
    chk("rst2_in_ready", a.in_ready, 0);
    chk("rst2_out_valid", a.out_valid, 0);
    tick();
    reset = 1'b0;
    b.in_valid = '0;

    // Round-robin sweep, all channels requesting.
    for (int c = 0; c < 10; c++) begin
      qa.push_back(mk(c % 8, 64'hA0 + 64'(c % 8)));
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("sweep_ready", a.in_ready, 64'd1 << (c % 8));
      if (c > 0) begin
        chk("sweep_ov", a.out_valid, 1);
        chk("sweep_chan", a.out_chan, 64'((c - 1) % 8));
      end
      tick();
    end
    a.in_valid = '0;
    tick();

    // Sparse requests and wrap.
    a.in_valid = 8'h20;
    qa.push_back(mk(5, 64'hA5));
    @(negedge clk);
    chk("sp_5", a.in_ready, 8'h20);
    tick();
    a.in_valid = 8'h44;
    qa.push_back(mk(6, 64'hA6));
    @(negedge clk);
    chk("sp_6_first", a.in_ready, 8'h40);
    tick();
    a.in_valid = 8'h04;
    qa.push_back(mk(2, 64'hA2));
    @(negedge clk);
    chk("sp_2_next", a.in_ready, 8'h04);
    tick();
    a.in_valid = 8'h80;
    qa.push_back(mk(7, 64'hA7));
    @(negedge clk);
    chk("sp_7", a.in_ready, 8'h80);
    tick();
    a.in_valid = 8'h42;
    qa.push_back(mk(1, 64'hA1));
    @(negedge clk);
    chk("wrap_1", a.in_ready, 8'h02);
    tick();
    a.in_valid = 8'h40;
    qa.push_back(mk(6, 64'hA6));
    @(negedge clk);
    chk("wrap_6", a.in_ready, 8'h40);
    tick();
    a.in_valid = '0;
    tick();

    // Backpressure with channel 3 waiting.
    a.out_ready = 1'b0;
    a.in_valid = 8'h01;
    qa.push_back(mk(0, 64'hA0));
    @(negedge clk);
    chk("bp_load", a.in_ready, 8'h01);
    tick();
    a.in_valid = 8'h08;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_ready", a.in_ready, 0);
      chk("bp_ov", a.out_valid, 1);
      chk("bp_chan", a.out_chan, 0);
      chk("bp_data", a.out_data, 64'hA0);
      chk("bp_ptr", u_rr.ptr, 1);
      tick();
    end
    a.out_ready = 1'b1;
    qa.push_back(mk(3, 64'hA3));
    @(negedge clk);
    chk("bp_release", a.in_ready, 8'h08);
    tick();
    a.in_valid = '0;
    @(negedge clk);
    chk("bp_next_ov", a.out_valid, 1);
    chk("bp_next_chan", a.out_chan, 3);
    tick();

    // Fixed priority instance.
    foreach (fp_vec[i]) begin
      b.in_valid = fp_vec[i].v;
      qb.push_back(mk(fp_vec[i].g, 64'hB0 + 64'(fp_vec[i].g)));
      @(negedge clk);
      chk("fp_ready", b.in_ready, 64'd1 << fp_vec[i].g);
      tick();
    end
    b.in_valid = '0;
    tick();
    tick();
    chk("fp_q_empty", qb.size(), 0);
    chk("dir_q_empty", qa.size(), 0);

    // Random traffic with resets at start and mid-run.
    model_on = 1'b1;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m_acc[i]) pend[i] = 1'b0;
      end
      m_acc = '0;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          seq++;
          pdata[i] = {8'(i), 24'(seq), 32'($urandom)};
        end
        a.in_data[i*W +: W] = pdata[i];
      end
      a.in_valid = pend;
      a.out_ready = ($urandom_range(0, 3) != 0);
      reset = (c < 2) || (c == 150) || (c == 151);
      tick();
    end
    reset = 1'b0;
    a.in_valid = '0;
    a.out_ready = 1'b1;
    tick();
    tick();
    tick();
    model_on = 1'b0;
    chk("rand_q_empty", qa.size(), 0);
    chk("rand_final_ov", a.out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_mux_stage.md
# rr_mux_stage

Parametrised, registered N-input arbitrating multiplexer with valid/ready handshakes. It is the next generation of the combinational 8:1 select tree. Instead of an external address, it picks among requesting channels by round-robin or fixed priority. The chosen word is captured into a single output register. Used wherever several pipeline producers share one downstream consumer, for example functional-unit results contending for a writeback port.

## Interface
Parameters:
- N, default 8: number of input channels; legal range 2..16.
- W, default 64: data width per channel, at least 1.
- RR, default 1: 1 = round-robin arbitration; 0 = fixed priority, channel 0 highest.
- CW = $clog2(N): derived; width of channel index.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- reset, input, 1: synchronous, active-high.
- in_valid, input, N: per-channel request.
- in_data, input, N*W: channel i occupies bits [i*W +: W].
- in_ready, output, N: per-channel accept; at most one bit set.
- out_valid, output, 1: output register holds a word.
- out_ready, input, 1: consumer accepts the word.
- out_data, output, W: registered selected word.
- out_chan, output, CW: index of the channel that supplied out_data.

## Operation
- State:
  - Output register: out_valid, out_data, out_chan.
  - Priority pointer ptr, CW bits, used only when RR=1.
- Reset values:
  - out_valid=0, out_data=0, out_chan=0, ptr=0.
  - in_ready is all zeros while reset is high.
- can_load = !out_valid || out_ready. This is combinational.
- Grant, combinational:
  - RR=1: the first i with in_valid[i] set, searching ptr, ptr+1, …, N-1, 0, …, ptr-1 with modulo-N wrap.
  - RR=0: the lowest i with in_valid[i] set.
- in_ready[i] = can_load && grant[i]. When no channel is valid, in_ready is all zeros.
- Transfer on channel i is in_valid[i] && in_ready[i]. At the next edge:
  - out_data <= in_data[i], out_chan <= i, out_valid <= 1.
  - When RR=1, ptr <= (i == N-1) ? 0 : i+1.
- Output drain is out_valid && out_ready. At the next edge:
  - If there is no simultaneous transfer, out_valid <= 0.
  - out_data and out_chan keep their last values.
- Simultaneous drain and transfer in the same cycle: the new word replaces the old one. out_valid stays 1. This gives one word per cycle at full throughput.
- Stall (out_valid && !out_ready):
  - All in_ready are 0.
  - out_data and out_chan hold stable.
  - ptr does not move.
- ptr changes only on a transfer. Idle cycles and stall cycles leave it unchanged.
- The block does not drop, duplicate or reorder words. Each accepted word appears on the output exactly once.
- in_data of non-granted channels is ignored. Producers must hold in_valid and in_data until they are accepted.

## Timing
- Latency from input transfer to out_valid is 1 cycle. The word is visible the cycle after acceptance.
- Throughput is 1 word per cycle when out_ready is held high.
- in_ready depends combinationally on in_valid, ptr, out_valid and out_ready. There is no combinational path from in_data to any output.
- Round-robin fairness: with all N channels continuously valid and out_ready=1, the grants cycle 0,1,…,N-1,0,… in that order. Each channel waits at most N-1 grants between services.
- Reset asserted in the middle of an operation:
  - At the next edge, any held word is discarded, out_valid goes to 0 and ptr goes to 0.
  - A transfer in the cycle where reset is high is not taken.
- Deasserting reset: arbitration is live in the first cycle with reset=0.

## Test plan
- Reset: hold reset 2 cycles with all in_valid=1. Required: in_ready=0, out_valid=0, out_data=0, out_chan=0. The first cycle after reset grants channel 0.
- Round-robin sweep (N=8, W=64, RR=1): all channels valid with in_data[i]=64'hA0+i, out_ready=1. Required: out_chan sequence 0..7,0,1 on consecutive cycles, each with matching out_data and no gaps.
- Sparse requests (RR=1): after a grant to channel 5, raise only channels 2 and 6. Required: channel 6 is granted first, then channel 2. Confirm the wrap from channel 7 back to 0 by raising only channel 1 after a grant to channel 7.
- Backpressure: hold out_ready=0 for 5 cycles with out_valid=1 and channel 3 requesting. Required: in_ready=0 throughout, out_data and out_chan stable, ptr unchanged. Then set out_ready=1. Required: the held word drains and channel 3's word appears the next cycle.
- Fixed priority (RR=0): channels 1, 4 and 7 all valid. Required: channel 1 wins every cycle until it drops, then 4, then 7.
- Mid-operation reset with random traffic: a scoreboard checks that every accepted word appears exactly once, in acceptance order. At reset, out_valid must go to 0 on the next edge and no stale word may reappear afterwards.
